mem_bus_arbiter: RTL and testbench

- Two-master, one-slave arbiter for the SoC native memory bus (valid/ready/addr/wdata/wstrb/rdata handshake).
- Lets a second requester (DMA/debug loader) share the program/data RAM and peripheral space with the CPU.
- Round-robin grant, held for a whole transaction.
- Bus watchdog terminates hung slave accesses and flags the error.

---
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
//
// Two-master, one-slave arbiter for the native memory bus. Master 0 is the
// CPU, master 1 a secondary requester (DMA / debug loader). Ownership is
// granted round-robin and held for one whole transaction; the bus always
// returns to IDLE between transactions. A watchdog ends slave accesses that
// never complete, answering the owner with ERR_DATA and raising a sticky
// error flag.
//
// Ports
//   clk, reset              system clock, asynchronous active-high reset
//   m0_* / m1_*             master request side (valid, addr, wdata, wstrb in;
//                           ready, rdata out). wstrb == 0 means read.
//   s_*                     slave side (valid, addr, wdata, wstrb out;
//                           ready, rdata in)
//   grant                   one-hot current owner, 00 when idle
//   timeout_err             sticky watchdog flag, cleared only by reset
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | no owner; arbitrate between pending requests
// OWN0   | master 0 owns the slave bus, its request is forwarded
// OWN1   | master 1 owns the slave bus, its request is forwarded
// ---------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_valid,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W-1:0]     m0_wdata,
    input  logic [DATA_W/8-1:0]   m0_wstrb,
    output logic                  m0_ready,
    output logic [DATA_W-1:0]     m0_rdata,

    input  logic                  m1_valid,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W-1:0]     m1_wdata,
    input  logic [DATA_W/8-1:0]   m1_wstrb,
    output logic                  m1_ready,
    output logic [DATA_W-1:0]     m1_rdata,

    output logic                  s_valid,
    output logic [ADDR_W-1:0]     s_addr,
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_ready,
    input  logic [DATA_W-1:0]     s_rdata,

    output logic [1:0]            grant,
    output logic                  timeout_err
);

    localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 last_owner;       // 1 = master 1 was served last
    logic                 last_owner_nxt;
    logic [WDOG_W-1:0]    wdog;
    logic [WDOG_W-1:0]    wdog_nxt;
    logic                 set_err;

    // Owner-selected request, valid only while a master owns the bus.
    logic                 sel;
    logic                 own_valid;
    logic [ADDR_W-1:0]    own_addr;
    logic [DATA_W-1:0]    own_wdata;
    logic [DATA_W/8-1:0]  own_wstrb;
    logic                 own_ready;
    logic [DATA_W-1:0]    own_rdata;
    logic                 expire;

    assign grant = {state == OWN1, state == OWN0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            wdog        <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_owner  <= last_owner_nxt;
            wdog        <= wdog_nxt;
            timeout_err <= timeout_err | set_err;
        end
    end

    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        wdog_nxt       = wdog;
        set_err        = 1'b0;
        expire         = 1'b0;
        own_ready      = 1'b0;
        own_rdata      = '0;

        s_valid  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;

        sel       = (state == OWN1);
        own_valid = sel ? m1_valid : m0_valid;
        own_addr  = sel ? m1_addr  : m0_addr;
        own_wdata = sel ? m1_wdata : m0_wdata;
        own_wstrb = sel ? m1_wstrb : m0_wstrb;

        case (state)
            IDLE: begin
                wdog_nxt = '0;
                // On a tie, the master that was not served last wins.
                if (m0_valid && m1_valid) begin
                    state_nxt = last_owner ? OWN0 : OWN1;
                end else if (m0_valid) begin
                    state_nxt = OWN0;
                end else if (m1_valid) begin
                    state_nxt = OWN1;
                end
            end

            OWN0, OWN1: begin
                // Last cycle the access may wait: answer the owner ourselves
                // and withdraw the request from the slave.
                expire = WDOG_EN && own_valid && !s_ready && (wdog == WDOG_LAST);

                s_valid   = own_valid && !expire;
                s_addr    = own_addr;
                s_wdata   = own_wdata;
                s_wstrb   = own_wstrb;
                own_ready = s_ready || expire;
                own_rdata = expire ? ERR_DATA : s_rdata;

                if (expire) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = sel;
                    wdog_nxt       = '0;
                    set_err        = 1'b1;
                end else if (!own_valid) begin
                    // Abandoned request: fairness history is left untouched.
                    state_nxt = IDLE;
                    wdog_nxt  = '0;
                end else if (s_ready) begin
                    state_nxt      = IDLE;
                    last_owner_nxt = sel;
                    wdog_nxt       = '0;
                end else if (WDOG_EN) begin
                    wdog_nxt = wdog + WDOG_W'(1);
                end

                if (sel) begin
                    m1_ready = own_ready;
                    m1_rdata = own_rdata;
                end else begin
                    m0_ready = own_ready;
                    m0_rdata = own_rdata;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
module tb_mem_bus_arbiter;

    localparam int NCYC = 300;
    localparam int MAXT = 160;
    localparam int NACC = 320;
    localparam int BIG  = 1 << 30;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(8),
        .ERR_DATA(32'hDEADBEEF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .m0_valid   (m0_valid),
        .m0_addr    (m0_addr),
        .m0_wdata   (m0_wdata),
        .m0_wstrb   (m0_wstrb),
        .m0_ready   (m0_ready),
        .m0_rdata   (m0_rdata),
        .m1_valid   (m1_valid),
        .m1_addr    (m1_addr),
        .m1_wdata   (m1_wdata),
        .m1_wstrb   (m1_wstrb),
        .m1_ready   (m1_ready),
        .m1_rdata   (m1_rdata),
        .s_valid    (s_valid),
        .s_addr     (s_addr),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_ready    (s_ready),
        .s_rdata    (s_rdata),
        .grant      (grant),
        .timeout_err(timeout_err)
    );

    // Random-phase stimulus tables and expected per-cycle results.
    logic [31:0] r_addr  [2][MAXT+1];
    logic [31:0] r_wdata [2][MAXT+1];
    logic [3:0]  r_wstrb [2][MAXT+1];
    int          r_gap   [2][MAXT+1];
    int          s_lat   [NACC+1];
    logic [31:0] s_dat   [NACC+1];

    logic [1:0]  exp_grant [NCYC];
    bit          exp_rdy   [2][NCYC];
    logic [31:0] exp_rd    [NCYC];
    logic [31:0] exp_addr  [NCYC];
    logic [31:0] exp_wdata [NCYC];
    logic [3:0]  exp_wstrb [NCYC];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] t2_exp [8];
        int req [2];
        int k   [2];
        int dreq[2];
        int dk  [2];
        int t, acc, last, o, lat, done, sacc, scnt;
        bit p0, p1;

        t2_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

        // Reset state
        reset = 1'b1;
        idle_inputs();
        m0_valid = 1'b1; m1_valid = 1'b1; s_ready = 1'b1; s_rdata = 32'hFFFF_FFFF;
        #3;
        chk("rst_grant",   grant, 2'b00);
        chk("rst_svalid",  s_valid, 1'b0);
        chk("rst_saddr",   s_addr, 32'h0);
        chk("rst_m0ready", m0_ready, 1'b0);
        chk("rst_m1rdata", m1_rdata, 32'h0);
        chk("rst_terr",    timeout_err, 1'b0);
        do_reset();

        // 1: single read
        step(); m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
        smp();  chk("t1_idle_grant", grant, 2'b00); chk("t1_idle_svalid", s_valid, 1'b0);
        step(); smp();
        chk("t1_grant", grant, 2'b01);
        chk("t1_svalid", s_valid, 1'b1);
        chk("t1_saddr", s_addr, 32'h100);
        chk("t1_swstrb", s_wstrb, 4'h0);
        chk("t1_m0ready_wait", m0_ready, 1'b0);
        step(); s_ready = 1'b1; s_rdata = 32'h1234_5678;
        smp();
        chk("t1_m0ready", m0_ready, 1'b1);
        chk("t1_m0rdata", m0_rdata, 32'h1234_5678);
        chk("t1_m1ready", m1_ready, 1'b0);
        chk("t1_m1rdata", m1_rdata, 32'h0);
        step(); m0_valid = 1'b0; s_ready = 1'b0;
        smp();  chk("t1_release", grant, 2'b00); chk("t1_m0ready_off", m0_ready, 1'b0);

        // 2: simultaneous requests from reset
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step();
            m0_valid = 1'b1; m0_addr = 32'h10; m1_valid = 1'b1; m1_addr = 32'h20;
            #1;
            s_ready = s_valid; s_rdata = 32'(i);
            smp();
            chk($sformatf("t2_grant%0d", i), grant, t2_exp[i]);
            chk($sformatf("t2_m0ready%0d", i), m0_ready, t2_exp[i] == 2'b01);
            chk($sformatf("t2_m1ready%0d", i), m1_ready, t2_exp[i] == 2'b10);
        end
        step(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        smp();  chk("t2_end", grant, 2'b00);

        // 3: write forwarding from m1, slave waits 3 cycles
        step(); m1_valid = 1'b1; m1_addr = 32'h2000_0004; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'b0110;
        smp();  chk("t3_idle", grant, 2'b00);
        for (int i = 0; i < 4; i++) begin
            step(); s_ready = (i == 3); s_rdata = 32'hCAFE_F00D;
            smp();
            chk($sformatf("t3_grant%0d", i), grant, 2'b10);
            chk($sformatf("t3_svalid%0d", i), s_valid, 1'b1);
            chk($sformatf("t3_saddr%0d", i), s_addr, 32'h2000_0004);
            chk($sformatf("t3_swdata%0d", i), s_wdata, 32'hA5A5_A5A5);
            chk($sformatf("t3_swstrb%0d", i), s_wstrb, 4'b0110);
            chk($sformatf("t3_m1ready%0d", i), m1_ready, i == 3);
            chk($sformatf("t3_m0ready%0d", i), m0_ready, 1'b0);
        end
        step(); m1_valid = 1'b0; s_ready = 1'b0;
        smp();  chk("t3_end", grant, 2'b00);

        // 4: watchdog, slave never answers
        step(); m0_valid = 1'b1; m0_addr = 32'h0000_0300; m0_wstrb = 4'h0;
        smp();
        for (int i = 1; i <= 8; i++) begin
            step(); smp();
            chk($sformatf("t4_grant%0d", i), grant, 2'b01);
            chk($sformatf("t4_m0ready%0d", i), m0_ready, i == 8);
            chk($sformatf("t4_svalid%0d", i), s_valid, i != 8);
            chk($sformatf("t4_terr%0d", i), timeout_err, 1'b0);
            if (i == 8) chk("t4_errdata", m0_rdata, 32'hDEADBEEF);
        end
        step(); m0_valid = 1'b0;
        smp();
        chk("t4_idle", grant, 2'b00);
        chk("t4_terr_set", timeout_err, 1'b1);
        step(); m1_valid = 1'b1; m1_addr = 32'h0000_0400; m1_wstrb = 4'h0;
        smp();
        step(); smp(); chk("t4_m1grant", grant, 2'b10);
        step(); s_ready = 1'b1; s_rdata = 32'h0000_55AA;
        smp();
        chk("t4_m1ready", m1_ready, 1'b1);
        chk("t4_m1rdata", m1_rdata, 32'h0000_55AA);
        step(); m1_valid = 1'b0; s_ready = 1'b0;
        smp();  chk("t4_terr_sticky", timeout_err, 1'b1);

        // 5: reset during an OWN1 wait state
        step(); m1_valid = 1'b1; m1_addr = 32'h0000_0500;
        smp();
        step(); smp(); chk("t5_grant", grant, 2'b10);
        step(); smp(); chk("t5_wait", grant, 2'b10);
        #2;
        reset = 1'b1; s_ready = 1'b1; s_rdata = 32'h1111_2222;
        #1;
        chk("t5_rst_grant", grant, 2'b00);
        chk("t5_rst_svalid", s_valid, 1'b0);
        chk("t5_rst_m1ready", m1_ready, 1'b0);
        chk("t5_rst_m1rdata", m1_rdata, 32'h0);
        chk("t5_rst_terr", timeout_err, 1'b0);
        m0_valid = 1'b1; m0_addr = 32'h0000_0510; s_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step(); smp(); chk("t5_tie_m0", grant, 2'b01);
        step(); s_ready = 1'b1; smp(); chk("t5_m0ready", m0_ready, 1'b1);
        step(); m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;
        smp();  chk("t5_end", grant, 2'b00);

        // 6: m1 abandons its request
        step(); m1_valid = 1'b1; m1_addr = 32'h0000_0600;
        smp();  chk("t6_idle", grant, 2'b00);
        step(); m0_valid = 1'b1; m0_addr = 32'h0000_0700;
        smp();  chk("t6_g1", grant, 2'b10);
        step(); smp(); chk("t6_g2", grant, 2'b10);
        step(); m1_valid = 1'b0;
        smp();
        chk("t6_drop_grant", grant, 2'b10);
        chk("t6_drop_svalid", s_valid, 1'b0);
        chk("t6_drop_m1ready", m1_ready, 1'b0);
        step(); smp(); chk("t6_gap", grant, 2'b00);
        step(); smp();
        chk("t6_m0grant", grant, 2'b01);
        chk("t6_m0addr", s_addr, 32'h0000_0700);
        step(); s_ready = 1'b1; smp(); chk("t6_m0ready", m0_ready, 1'b1);
        step(); m0_valid = 1'b0; s_ready = 1'b0; smp();

        // Random phase: build tables, predict at transaction level, then drive.
        for (int n = 0; n < 2; n++) begin
            for (int j = 0; j <= MAXT; j++) begin
                r_addr[n][j]  = $urandom;
                r_wdata[n][j] = $urandom;
                r_wstrb[n][j] = 4'($urandom_range(0, 15));
                r_gap[n][j]   = $urandom_range(0, 3);
            end
        end
        for (int j = 0; j <= NACC; j++) begin
            s_lat[j] = $urandom_range(0, 4);
            s_dat[j] = $urandom;
        end
        for (int c = 0; c < NCYC; c++) begin
            exp_grant[c] = 2'b00; exp_rdy[0][c] = 1'b0; exp_rdy[1][c] = 1'b0;
            exp_rd[c] = '0; exp_addr[c] = '0; exp_wdata[c] = '0; exp_wstrb[c] = '0;
        end

        // Model: an arbitration decision in an idle cycle t grants cycles
        // t+1 .. t+1+lat; the owner completes on the last of these and the bus
        // is idle again on the following cycle.
        t = 0; acc = 0; last = 1;
        k[0] = 0; k[1] = 0;
        req[0] = r_gap[0][0]; req[1] = r_gap[1][0];
        while (t < NCYC) begin
            p0 = (req[0] <= t);
            p1 = (req[1] <= t);
            if (!p0 && !p1) begin
                t = (req[0] < req[1]) ? req[0] : req[1];
            end else begin
                o = (p0 && p1) ? (1 - last) : (p0 ? 0 : 1);
                lat  = s_lat[acc];
                done = t + 1 + lat;
                for (int c = t + 1; c <= done && c < NCYC; c++) begin
                    exp_grant[c] = (o == 1) ? 2'b10 : 2'b01;
                    exp_addr[c]  = r_addr[o][k[o]];
                    exp_wdata[c] = r_wdata[o][k[o]];
                    exp_wstrb[c] = r_wstrb[o][k[o]];
                end
                if (done < NCYC) begin
                    exp_rdy[o][done] = 1'b1;
                    exp_rd[done]     = s_dat[acc];
                end
                acc++;
                k[o]++;
                req[o] = (k[o] < MAXT) ? done + 1 + r_gap[o][k[o]] : BIG;
                last = o;
                t = done + 1;
            end
        end

        do_reset();
        dk[0] = 0; dk[1] = 0;
        dreq[0] = r_gap[0][0]; dreq[1] = r_gap[1][0];
        sacc = 0; scnt = 0;
        for (int c = 0; c < NCYC; c++) begin
            step();
            m0_valid = (dk[0] < MAXT) && (c >= dreq[0]);
            m0_addr  = r_addr[0][dk[0]]; m0_wdata = r_wdata[0][dk[0]]; m0_wstrb = r_wstrb[0][dk[0]];
            m1_valid = (dk[1] < MAXT) && (c >= dreq[1]);
            m1_addr  = r_addr[1][dk[1]]; m1_wdata = r_wdata[1][dk[1]]; m1_wstrb = r_wstrb[1][dk[1]];
            #1;
            if (s_valid) begin
                s_ready = (scnt == s_lat[sacc]);
                s_rdata = s_ready ? s_dat[sacc] : $urandom;
            end else begin
                // Stray ready while nothing is requested must be ignored.
                s_ready = 1'($urandom_range(0, 1));
                s_rdata = $urandom;
            end
            smp();
            chk($sformatf("rnd_grant_c%0d", c), grant, exp_grant[c]);
            chk($sformatf("rnd_m0ready_c%0d", c), m0_ready, exp_rdy[0][c]);
            chk($sformatf("rnd_m1ready_c%0d", c), m1_ready, exp_rdy[1][c]);
            if (exp_rdy[0][c]) chk($sformatf("rnd_m0rdata_c%0d", c), m0_rdata, exp_rd[c]);
            if (exp_rdy[1][c]) chk($sformatf("rnd_m1rdata_c%0d", c), m1_rdata, exp_rd[c]);
            if (exp_grant[c] != 2'b00) begin
                chk($sformatf("rnd_svalid_c%0d", c), s_valid, 1'b1);
                chk($sformatf("rnd_saddr_c%0d", c), s_addr, exp_addr[c]);
                chk($sformatf("rnd_swdata_c%0d", c), s_wdata, exp_wdata[c]);
                chk($sformatf("rnd_swstrb_c%0d", c), s_wstrb, exp_wstrb[c]);
            end else begin
                chk($sformatf("rnd_svalid_c%0d", c), s_valid, 1'b0);
            end
            if (s_valid && s_ready) begin
                if (sacc < NACC) sacc++;
                scnt = 0;
            end else if (s_valid) begin
                scnt++;
            end
            if (m0_ready && dk[0] < MAXT) begin
                dk[0]++;
                dreq[0] = c + 1 + r_gap[0][dk[0]];
            end
            if (m1_ready && dk[1] < MAXT) begin
                dk[1]++;
                dreq[1] = c + 1 + r_gap[1][dk[1]];
            end
        end
        chk("rnd_no_timeout", timeout_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
